// File: rtl/bram_rr_arbiter.sv
// Round-robin sharing of one single-cycle BRAM between clients A and B, with per-client read return.
// Define BRAM_ARB_ZERO_INIT_EN to zero every BRAM word after reset before clients are served.
module bram_rr_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  REQ_VALID_A,
  output logic                  REQ_READY_A,
  input  logic                  REQ_WRITE_A,
  input  logic [ADDR_WIDTH-1:0] REQ_ADDR_A,
  input  logic [DATA_WIDTH-1:0] REQ_DATA_A,
  input  logic                  REQ_VALID_B,
  output logic                  REQ_READY_B,
  input  logic                  REQ_WRITE_B,
  input  logic [ADDR_WIDTH-1:0] REQ_ADDR_B,
  input  logic [DATA_WIDTH-1:0] REQ_DATA_B,
  output logic                  RSP_VALID_A,
  output logic                  RSP_VALID_B,
  output logic [DATA_WIDTH-1:0] RSP_DATA,
  output logic [DATA_WIDTH-1:0] M_DI,
  output logic [ADDR_WIDTH-1:0] M_WR_ADDR,
  output logic [ADDR_WIDTH-1:0] M_RD_ADDR,
  output logic                  M_WE,
  output logic                  M_RE,
  input  logic [DATA_WIDTH-1:0] M_DO,
  input  logic                  M_DO_VALID,
  output logic                  BUSY
);

  typedef enum logic {INIT, RUN} state_t;
  typedef enum logic {CLIENT_A, CLIENT_B} client_t;

`ifdef BRAM_ARB_ZERO_INIT_EN
  localparam state_t RESET_STATE = INIT;
  localparam logic [ADDR_WIDTH-1:0] INIT_LAST = '1;
  logic [ADDR_WIDTH-1:0] init_addr, init_addr_nxt;
`else
  localparam state_t RESET_STATE = RUN;
`endif

  state_t  state, state_nxt;
  client_t rr_ptr, rr_ptr_nxt;
  client_t rsp_owner, rsp_owner_nxt;
  logic    rd_pending, rd_pending_nxt;

  logic [ADDR_WIDTH-1:0] wr_addr_q, rd_addr_q;
  logic [DATA_WIDTH-1:0] di_q;

  logic                  run_active, grant_a, grant_b;
  logic                  sel_write;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;

  // Round-robin grant; reset forces every output low even while the state reads RUN.
  assign run_active = !RST && (state == RUN);
  assign grant_a    = run_active && REQ_VALID_A && (!REQ_VALID_B || rr_ptr == CLIENT_A);
  assign grant_b    = run_active && REQ_VALID_B && !grant_a;
  assign sel_write  = grant_b ? REQ_WRITE_B : REQ_WRITE_A;
  assign sel_addr   = grant_b ? REQ_ADDR_B  : REQ_ADDR_A;
  assign sel_data   = grant_b ? REQ_DATA_B  : REQ_DATA_A;

  assign REQ_READY_A = grant_a;
  assign REQ_READY_B = grant_b;
  assign BUSY        = (state == INIT);

  // rd_pending masks a response whose read was issued before an intervening reset.
  assign RSP_VALID_A = M_DO_VALID && rd_pending && (rsp_owner == CLIENT_A);
  assign RSP_VALID_B = M_DO_VALID && rd_pending && (rsp_owner == CLIENT_B);
  assign RSP_DATA    = M_DO;

  always_comb begin
    state_nxt      = state;
    rr_ptr_nxt     = rr_ptr;
    rsp_owner_nxt  = rsp_owner;
    rd_pending_nxt = 1'b0;
    M_WE           = 1'b0;
    M_RE           = 1'b0;
    M_WR_ADDR      = wr_addr_q;
    M_RD_ADDR      = rd_addr_q;
    M_DI           = di_q;
`ifdef BRAM_ARB_ZERO_INIT_EN
    init_addr_nxt  = init_addr;
`endif
    if (!RST) begin
      case (state)
`ifdef BRAM_ARB_ZERO_INIT_EN
        INIT: begin
          M_WE          = 1'b1;
          M_WR_ADDR     = init_addr;
          M_DI          = '0;
          init_addr_nxt = init_addr + ADDR_WIDTH'(1);
          if (init_addr == INIT_LAST) state_nxt = RUN;
        end
`endif
        RUN: begin
          if (grant_a || grant_b) begin
            rr_ptr_nxt = grant_a ? CLIENT_B : CLIENT_A;
            if (sel_write) begin
              M_WE      = 1'b1;
              M_WR_ADDR = sel_addr;
              M_DI      = sel_data;
            end else begin
              M_RE           = 1'b1;
              M_RD_ADDR      = sel_addr;
              rsp_owner_nxt  = grant_b ? CLIENT_B : CLIENT_A;
              rd_pending_nxt = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= RESET_STATE;
      rr_ptr     <= CLIENT_A;
      rsp_owner  <= CLIENT_A;
      rd_pending <= 1'b0;
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      di_q       <= '0;
`ifdef BRAM_ARB_ZERO_INIT_EN
      init_addr  <= '0;
`endif
    end else begin
      state      <= state_nxt;
      rr_ptr     <= rr_ptr_nxt;
      rsp_owner  <= rsp_owner_nxt;
      rd_pending <= rd_pending_nxt;
      wr_addr_q  <= M_WR_ADDR;
      rd_addr_q  <= M_RD_ADDR;
      di_q       <= M_DI;
`ifdef BRAM_ARB_ZERO_INIT_EN
      init_addr  <= init_addr_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_bram_rr_arbiter.sv
// Self-checking bench for bram_rr_arbiter: behavioural BRAM, read scoreboard, directed arbitration cases.
// Covers both builds of BRAM_ARB_ZERO_INIT_EN.
module tb_bram_rr_arbiter;
  localparam int unsigned DW = 8;
  localparam int unsigned AW = 4;
  localparam int unsigned DEPTH = 16;

  logic          CLK = 1'b0;
  logic          RST;
  logic          REQ_VALID_A, REQ_READY_A, REQ_WRITE_A;
  logic [AW-1:0] REQ_ADDR_A;
  logic [DW-1:0] REQ_DATA_A;
  logic          REQ_VALID_B, REQ_READY_B, REQ_WRITE_B;
  logic [AW-1:0] REQ_ADDR_B;
  logic [DW-1:0] REQ_DATA_B;
  logic          RSP_VALID_A, RSP_VALID_B;
  logic [DW-1:0] RSP_DATA, M_DI, M_DO;
  logic [AW-1:0] M_WR_ADDR, M_RD_ADDR;
  logic          M_WE, M_RE, M_DO_VALID, BUSY;

  bram_rr_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .CLK(CLK), .RST(RST),
    .REQ_VALID_A(REQ_VALID_A), .REQ_READY_A(REQ_READY_A), .REQ_WRITE_A(REQ_WRITE_A),
    .REQ_ADDR_A(REQ_ADDR_A), .REQ_DATA_A(REQ_DATA_A),
    .REQ_VALID_B(REQ_VALID_B), .REQ_READY_B(REQ_READY_B), .REQ_WRITE_B(REQ_WRITE_B),
    .REQ_ADDR_B(REQ_ADDR_B), .REQ_DATA_B(REQ_DATA_B),
    .RSP_VALID_A(RSP_VALID_A), .RSP_VALID_B(RSP_VALID_B), .RSP_DATA(RSP_DATA),
    .M_DI(M_DI), .M_WR_ADDR(M_WR_ADDR), .M_RD_ADDR(M_RD_ADDR),
    .M_WE(M_WE), .M_RE(M_RE), .M_DO(M_DO), .M_DO_VALID(M_DO_VALID), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

`ifdef BRAM_ARB_ZERO_INIT_EN
  localparam logic INIT_BUILD = 1'b1;
`else
  localparam logic INIT_BUILD = 1'b0;
`endif

  // Behavioural BRAM: 1-cycle read latency, zero output when not read-enabled; not reset.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge CLK) begin
    if (M_WE) mem[M_WR_ADDR] <= M_DI;
    if (M_RE) begin
      M_DO       <= mem[M_RD_ADDR];
      M_DO_VALID <= 1'b1;
    end else begin
      M_DO       <= '0;
      M_DO_VALID <= 1'b0;
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  typedef struct {
    int            cyc;
    logic          to_b;
    logic [DW-1:0] data;
    logic          known;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] ref_mem [DEPTH];
  logic          known   [DEPTH];
  int            cyc = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  // Client-side reference memory and response scoreboard, sampled mid-cycle.
  always @(negedge CLK) begin
    exp_t e;
    if (RST) begin
      exp_q.delete();
      chk("rst_rsp_a", 32'(RSP_VALID_A), 0);
      chk("rst_rsp_b", 32'(RSP_VALID_B), 0);
      if (INIT_BUILD) for (int i = 0; i < DEPTH; i++) begin ref_mem[i] = '0; known[i] = 1'b1; end
    end else begin
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        e = exp_q.pop_front();
        chk("rsp_valid_a", 32'(RSP_VALID_A), 32'(!e.to_b));
        chk("rsp_valid_b", 32'(RSP_VALID_B), 32'(e.to_b));
        if (e.known) chk("rsp_data", 32'(RSP_DATA), 32'(e.data));
      end else if (RSP_VALID_A || RSP_VALID_B) begin
        chk("rsp_spurious", {30'd0, RSP_VALID_A, RSP_VALID_B}, 0);
      end
      chk("ready_excl", 32'(REQ_READY_A && REQ_READY_B), 0);
      if (REQ_VALID_A && REQ_READY_A) begin
        if (REQ_WRITE_A) begin ref_mem[REQ_ADDR_A] = REQ_DATA_A; known[REQ_ADDR_A] = 1'b1; end
        else exp_q.push_back('{cyc + 1, 1'b0, ref_mem[REQ_ADDR_A], known[REQ_ADDR_A]});
      end
      if (REQ_VALID_B && REQ_READY_B) begin
        if (REQ_WRITE_B) begin ref_mem[REQ_ADDR_B] = REQ_DATA_B; known[REQ_ADDR_B] = 1'b1; end
        else exp_q.push_back('{cyc + 1, 1'b1, ref_mem[REQ_ADDR_B], known[REQ_ADDR_B]});
      end
    end
  end

  task automatic step();
    @(posedge CLK); #1;
  endtask

  // Present one request, require acceptance in its first cycle, then hold until accepted.
  task automatic issue(input string tag, input logic to_b, input logic wr,
                       input logic [AW-1:0] addr, input logic [DW-1:0] data);
    logic rdy;
    int   n;
    if (to_b) begin REQ_VALID_B = 1; REQ_WRITE_B = wr; REQ_ADDR_B = addr; REQ_DATA_B = data; end
    else      begin REQ_VALID_A = 1; REQ_WRITE_A = wr; REQ_ADDR_A = addr; REQ_DATA_A = data; end
    @(negedge CLK);
    rdy = to_b ? REQ_READY_B : REQ_READY_A;
    chk(tag, 32'(rdy), 1);
    n = 0;
    while (!rdy && n < 20) begin
      step(); @(negedge CLK);
      rdy = to_b ? REQ_READY_B : REQ_READY_A;
      n++;
    end
    step();
    if (to_b) REQ_VALID_B = 0; else REQ_VALID_A = 0;
  endtask

  task automatic wait_init(input string tag);
    int n;
    n = 0;
    @(negedge CLK);
    while (BUSY && n < 40) begin step(); @(negedge CLK); n++; end
    chk(tag, 32'(BUSY), 0);
    step();
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin known[i] = 1'b0; ref_mem[i] = '0; mem[i] = '0; end
    M_DO = '0; M_DO_VALID = 1'b0;
    RST = 1;
    REQ_VALID_A = 0; REQ_WRITE_A = 0; REQ_ADDR_A = '0; REQ_DATA_A = '0;
    REQ_VALID_B = 0; REQ_WRITE_B = 0; REQ_ADDR_B = '0; REQ_DATA_B = '0;
    repeat (2) step();

    // Reset values, with a request pending that must not be accepted.
    REQ_VALID_A = 1;
    @(negedge CLK);
    chk("rst_busy", 32'(BUSY), 32'(INIT_BUILD));
    chk("rst_ready_a", 32'(REQ_READY_A), 0);
    chk("rst_we", 32'(M_WE), 0);
    chk("rst_re", 32'(M_RE), 0);
    chk("rst_wr_addr", 32'(M_WR_ADDR), 0);
    step();
    REQ_VALID_A = 0;
    RST = 0;

    if (INIT_BUILD) begin
      for (int i = 0; i < DEPTH; i++) begin
        @(negedge CLK);
        chk("init_busy", 32'(BUSY), 1);
        chk("init_we", 32'(M_WE), 1);
        chk("init_addr", 32'(M_WR_ADDR), 32'(i));
        chk("init_di", 32'(M_DI), 0);
        step();
      end
      @(negedge CLK);
      chk("init_end_busy", 32'(BUSY), 0);
      step();
      issue("init_rd7", 1'b0, 1'b0, 4'd7, 8'h00);
    end else begin
      chk("noinit_busy", 32'(BUSY), 0);
      issue("noinit_first", 1'b0, 1'b1, 4'd0, 8'h33);
    end

    // Single client: write then read back on the next cycle.
    issue("single_wr", 1'b0, 1'b1, 4'd3, 8'h5A);
    issue("single_rd", 1'b0, 1'b0, 4'd3, 8'h00);
    repeat (2) step();

    // Contention right after reset: grants alternate starting with A.
    RST = 1; step(); RST = 0;
    if (INIT_BUILD) wait_init("cont_init");
    REQ_VALID_A = 1; REQ_WRITE_A = 0; REQ_ADDR_A = 4'd3;
    REQ_VALID_B = 1; REQ_WRITE_B = 0; REQ_ADDR_B = 4'd0;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      chk("cont_ready_a", 32'(REQ_READY_A), 32'(k % 2 == 0));
      chk("cont_ready_b", 32'(REQ_READY_B), 32'(k % 2 == 1));
      step();
    end
    REQ_VALID_A = 0; REQ_VALID_B = 0;
    step();

    // Mixed ops with rr_ptr at A: A's write wins, B's read follows and sees it.
    REQ_VALID_A = 1; REQ_WRITE_A = 1; REQ_ADDR_A = 4'd2; REQ_DATA_A = 8'h11;
    REQ_VALID_B = 1; REQ_WRITE_B = 0; REQ_ADDR_B = 4'd2;
    @(negedge CLK);
    chk("mix_ready_a", 32'(REQ_READY_A), 1);
    chk("mix_ready_b", 32'(REQ_READY_B), 0);
    step();
    REQ_VALID_A = 0;
    @(negedge CLK);
    chk("mix_ready_b2", 32'(REQ_READY_B), 1);
    step();
    REQ_VALID_B = 0;

    // Pointer holds across idle cycles: after an A grant, contention goes to B.
    issue("hold_a", 1'b0, 1'b0, 4'd2, 8'h00);
    repeat (2) step();
    REQ_VALID_A = 1; REQ_WRITE_A = 0; REQ_ADDR_A = 4'd2;
    REQ_VALID_B = 1; REQ_WRITE_B = 0; REQ_ADDR_B = 4'd3;
    @(negedge CLK);
    chk("hold_ready_b", 32'(REQ_READY_B), 1);
    chk("hold_ready_a", 32'(REQ_READY_A), 0);
    step();
    REQ_VALID_B = 0;
    @(negedge CLK);
    chk("hold_ready_a2", 32'(REQ_READY_A), 1);
    step();
    REQ_VALID_A = 0;
    repeat (2) step();

    // Reset while B's read data is coming back: the response is dropped.
    REQ_VALID_B = 1; REQ_WRITE_B = 0; REQ_ADDR_B = 4'd2;
    @(negedge CLK);
    chk("mid_ready_b", 32'(REQ_READY_B), 1);
    step();
    RST = 1; REQ_VALID_B = 0;
    #1;
    chk("mid_bram_dv", 32'(M_DO_VALID), 1);
    chk("mid_rsp_b", 32'(RSP_VALID_B), 0);
    chk("mid_rsp_a", 32'(RSP_VALID_A), 0);
    chk("mid_re", 32'(M_RE), 0);
    chk("mid_we", 32'(M_WE), 0);
    chk("mid_busy", 32'(BUSY), 32'(INIT_BUILD));
    step();
    RST = 0;
    if (INIT_BUILD) begin
      @(negedge CLK);
      chk("restart_addr", 32'(M_WR_ADDR), 0);
      chk("restart_we", 32'(M_WE), 1);
      step();
      wait_init("restart_done");
    end
    issue("post_rst_rd", 1'b1, 1'b0, 4'd2, 8'h00);
    repeat (3) step();
    chk("sb_empty", 32'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
